// File: rtl/vend_pkg.sv
// Shared definitions for the vending sequencer: FSM states, selection codes,
// coin values in quarter units and default prices.
// Imported by vend_sequencer and change_payout.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VEND = 2'd1,
        PAY  = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_1    = 2'b01;
    localparam logic [1:0] SEL_2    = 2'b10;

    localparam int QUARTER_VAL = 1;
    localparam int DOLLAR_VAL  = 4;

    localparam int DEF_PRICE1         = 4;
    localparam int DEF_PRICE2         = 6;
    localparam int DEF_MAX_CREDIT     = 8;
    localparam int DEF_CREDIT_W       = 4;
    localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/change_payout.sv
// Change payout engine: pays a loaded amount coin-by-coin to the hopper,
// dollars first, then quarters, with one idle GAP cycle between coins.
// Ports: load/amount start a payout (accepted only when idle); coin_ack from
// the hopper; coin_req/coin_dollar registered hopper request; paid = value
// retired this cycle (for the caller's credit); done = last GAP cycle.
module change_payout
    import vend_pkg::*;
#(
    parameter int CREDIT_W = DEF_CREDIT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [CREDIT_W-1:0] amount,
    input  logic                coin_ack,
    output logic                coin_req,
    output logic                coin_dollar,
    output logic [CREDIT_W-1:0] paid,
    output logic                done
);

    localparam logic [CREDIT_W-1:0] Q_VAL = CREDIT_W'(QUARTER_VAL);
    localparam logic [CREDIT_W-1:0] D_VAL = CREDIT_W'(DOLLAR_VAL);

    state_t              state;
    logic [CREDIT_W-1:0] remaining;
    logic [CREDIT_W-1:0] coin_val;

    // Value of the coin currently being requested; only meaningful in PAY.
    assign coin_val = coin_dollar ? D_VAL : Q_VAL;
    assign paid     = (state == PAY && coin_ack) ? coin_val : '0;
    assign done     = (state == GAP) && (remaining == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            remaining   <= '0;
            coin_req    <= 1'b0;
            coin_dollar <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load && amount != '0) begin
                        remaining   <= amount;
                        coin_req    <= 1'b1;
                        coin_dollar <= (amount >= D_VAL);
                        state       <= PAY;
                    end
                end
                PAY: begin
                    // coin_dollar was chosen against remaining, so the
                    // subtraction can never wrap.
                    if (coin_ack) begin
                        remaining   <= remaining - coin_val;
                        coin_req    <= 1'b0;
                        coin_dollar <= 1'b0;
                        state       <= GAP;
                    end
                end
                GAP: begin
                    if (remaining != '0) begin
                        coin_req    <= 1'b1;
                        coin_dollar <= (remaining >= D_VAL);
                        state       <= PAY;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/vend_sequencer.sv
// Vending controller: accumulates coin credit, arbitrates cancel > coin >
// selection, requests a vend and then pays change through change_payout.
// Ports: front-panel pulses (quarter_in, dollar_in, selection, cancel),
// dispenser handshake (vend_req/vend_item/vend_done), hopper handshake
// (coin_req/coin_dollar/coin_ack), status (credit, coin_reject, busy, vend_fault).
// Optional: define VEND_TIMEOUT_EN to add a vend_done watchdog that refunds
// all credit after TIMEOUT_CYCLES cycles in VEND.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int PRICE1         = DEF_PRICE1,
    parameter int PRICE2         = DEF_PRICE2,
    parameter int MAX_CREDIT     = DEF_MAX_CREDIT,
    parameter int CREDIT_W       = DEF_CREDIT_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                quarter_in,
    input  logic                dollar_in,
    input  logic [1:0]          selection,
    input  logic                cancel,
    input  logic                vend_done,
    input  logic                coin_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend_req,
    output logic [1:0]          vend_item,
    output logic                coin_req,
    output logic                coin_dollar,
    output logic                coin_reject,
    output logic                busy,
    output logic                vend_fault
);

    localparam logic [CREDIT_W-1:0] Q_VAL = CREDIT_W'(QUARTER_VAL);
    localparam logic [CREDIT_W-1:0] D_VAL = CREDIT_W'(DOLLAR_VAL);
    localparam logic [CREDIT_W-1:0] P1    = CREDIT_W'(PRICE1);
    localparam logic [CREDIT_W-1:0] P2    = CREDIT_W'(PRICE2);
    localparam logic [CREDIT_W:0]   MAXC  = (CREDIT_W+1)'(MAX_CREDIT);

    // The top FSM uses IDLE, VEND and PAY; PAY covers the whole payout,
    // including the GAP cycles tracked inside change_payout.
    state_t              state;
    logic                coin_in;
    logic                dollar_fits;
    logic                quarter_fits;
    logic                sel_ok;
    logic [CREDIT_W-1:0] price;
    logic                do_cancel;
    logic                do_done;
    logic                timeout_hit;
    logic                pay_load;
    logic [CREDIT_W-1:0] pay_amount;
    logic [CREDIT_W-1:0] paid;
    logic                pay_done;

    assign coin_in      = quarter_in | dollar_in;
    assign dollar_fits  = ({1'b0, credit} + {1'b0, D_VAL}) <= MAXC;
    assign quarter_fits = ({1'b0, credit} + {1'b0, Q_VAL}) <= MAXC;
    assign sel_ok       = (selection == SEL_1 && credit >= P1) ||
                          (selection == SEL_2 && credit >= P2);
    assign price        = (vend_item == SEL_2) ? P2 : P1;
    assign busy         = (state != IDLE);

    assign do_cancel = (state == IDLE) && cancel && (credit != '0);
    assign do_done   = (state == VEND) && vend_done;

    // Change after a vend is credit-price; a cancel or timeout refunds it all.
    assign pay_amount = do_done ? (credit - price) : credit;
    assign pay_load   = do_cancel || timeout_hit ||
                        (do_done && credit != price);

`ifdef VEND_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCNT_W-1:0] TLAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    logic [TCNT_W-1:0] tcnt;
    logic              fault_q;

    // tcnt is 0 in the first VEND cycle, so the TIMEOUT_CYCLES-th VEND
    // cycle without vend_done triggers the refund.
    assign timeout_hit = (state == VEND) && !vend_done && (tcnt == TLAST);
    assign vend_fault  = fault_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt    <= '0;
            fault_q <= 1'b0;
        end else begin
            fault_q <= timeout_hit;
            if (state == VEND) tcnt <= tcnt + 1'b1;
            else               tcnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign vend_fault  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            credit      <= '0;
            vend_req    <= 1'b0;
            vend_item   <= SEL_NONE;
            coin_reject <= 1'b0;
        end else begin
            coin_reject <= 1'b0;
            case (state)
                IDLE: begin
                    if (do_cancel) begin
                        coin_reject <= coin_in;
                        state       <= PAY;
                    end else if (dollar_in) begin
                        if (dollar_fits) credit <= credit + D_VAL;
                        // A simultaneous quarter always goes to the chute.
                        coin_reject <= quarter_in | ~dollar_fits;
                    end else if (quarter_in) begin
                        if (quarter_fits) credit <= credit + Q_VAL;
                        coin_reject <= ~quarter_fits;
                    end else if (sel_ok) begin
                        vend_req  <= 1'b1;
                        vend_item <= selection;
                        state     <= VEND;
                    end
                end
                VEND: begin
                    coin_reject <= coin_in;
                    if (vend_done) begin
                        vend_req  <= 1'b0;
                        vend_item <= SEL_NONE;
                        credit    <= credit - price;
                        state     <= (credit != price) ? PAY : IDLE;
                    end else if (timeout_hit) begin
                        vend_req  <= 1'b0;
                        vend_item <= SEL_NONE;
                        state     <= PAY;
                    end
                end
                PAY: begin
                    coin_reject <= coin_in;
                    credit      <= credit - paid;
                    if (pay_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    change_payout #(
        .CREDIT_W (CREDIT_W)
    ) u_payout (
        .clk         (clk),
        .reset       (reset),
        .load        (pay_load),
        .amount      (pay_amount),
        .coin_ack    (coin_ack),
        .coin_req    (coin_req),
        .coin_dollar (coin_dollar),
        .paid        (paid),
        .done        (pay_done)
    );

endmodule

// File: tb/tb_vend_sequencer.sv
module tb_vend_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       quarter_in, dollar_in, cancel, vend_done, coin_ack;
    logic [1:0] selection;
    logic [3:0] credit;
    logic       vend_req, coin_req, coin_dollar, coin_reject, busy, vend_fault;
    logic [1:0] vend_item;

    int errors = 0;
    int checks = 0;

`ifdef VEND_TIMEOUT_EN
    localparam int TO = 10;
`else
    localparam int TO = 255;
`endif

    vend_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .quarter_in  (quarter_in),
        .dollar_in   (dollar_in),
        .selection   (selection),
        .cancel      (cancel),
        .vend_done   (vend_done),
        .coin_ack    (coin_ack),
        .credit      (credit),
        .vend_req    (vend_req),
        .vend_item   (vend_item),
        .coin_req    (coin_req),
        .coin_dollar (coin_dollar),
        .coin_reject (coin_reject),
        .busy        (busy),
        .vend_fault  (vend_fault)
    );

    always #5 clk = ~clk;

    // One record = inputs applied for one cycle, and the outputs expected
    // right after the clock edge that consumes them.
    typedef struct {
        logic       q, d;
        logic [1:0] sel;
        logic       c, vd, ack;
        logic [3:0] credit;
        logic       vreq;
        logic [1:0] vitem;
        logic       creq, cdol, crej, busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic q, d, input logic [1:0] sel,
                       input logic c, vd, ack,
                       input logic [3:0] cr, input logic vreq,
                       input logic [1:0] vitem,
                       input logic creq, cdol, crej, bsy);
        vec_t v;
        v.q = q; v.d = d; v.sel = sel; v.c = c; v.vd = vd; v.ack = ack;
        v.credit = cr; v.vreq = vreq; v.vitem = vitem;
        v.creq = creq; v.cdol = cdol; v.crej = crej; v.busy = bsy;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic q, d, input logic [1:0] sel, input logic c, vd, ack);
        quarter_in = q; dollar_in = d; selection = sel;
        cancel = c; vend_done = vd; coin_ack = ack;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, " credit"}, 8'(credit), 8'd0);
        chk({tag, " vend_req"}, 8'(vend_req), 8'd0);
        chk({tag, " vend_item"}, 8'(vend_item), 8'd0);
        chk({tag, " coin_req"}, 8'(coin_req), 8'd0);
        chk({tag, " coin_dollar"}, 8'(coin_dollar), 8'd0);
        chk({tag, " coin_reject"}, 8'(coin_reject), 8'd0);
        chk({tag, " busy"}, 8'(busy), 8'd0);
        chk({tag, " vend_fault"}, 8'(vend_fault), 8'd0);
    endtask

    initial begin
        //   q d sel   c vd ack | cr vreq item  creq cdol crej busy
        // four quarters, select item 1, exact price
        add(1,0,2'b00,0,0,0,  1, 0,2'b00, 0,0,0,0);
        add(1,0,2'b00,0,0,0,  2, 0,2'b00, 0,0,0,0);
        add(1,0,2'b00,0,0,0,  3, 0,2'b00, 0,0,0,0);
        add(1,0,2'b00,0,0,0,  4, 0,2'b00, 0,0,0,0);
        add(0,0,2'b01,0,0,0,  4, 1,2'b01, 0,0,0,1);
        add(0,0,2'b00,0,0,0,  4, 1,2'b01, 0,0,0,1);
        add(0,0,2'b00,0,1,0,  0, 0,2'b00, 0,0,0,0);
        add(0,0,2'b00,0,0,0,  0, 0,2'b00, 0,0,0,0);
        // two dollars, item 2, two quarters change with a GAP between
        add(0,1,2'b00,0,0,0,  4, 0,2'b00, 0,0,0,0);
        add(0,1,2'b00,0,0,0,  8, 0,2'b00, 0,0,0,0);
        add(0,0,2'b10,0,0,0,  8, 1,2'b10, 0,0,0,1);
        add(0,0,2'b00,0,1,0,  2, 0,2'b00, 1,0,0,1);
        add(0,0,2'b00,0,0,0,  2, 0,2'b00, 1,0,0,1);
        add(0,0,2'b00,0,0,1,  1, 0,2'b00, 0,0,0,1);
        add(0,0,2'b00,0,0,0,  1, 0,2'b00, 1,0,0,1);
        add(0,0,2'b00,0,0,1,  0, 0,2'b00, 0,0,0,1);
        add(0,0,2'b00,0,0,1,  0, 0,2'b00, 0,0,0,0);
        add(0,0,2'b00,0,1,1,  0, 0,2'b00, 0,0,0,0);
        // credit 7, dollar rejected, quarter to 8, quarter at max rejected
        add(0,1,2'b00,0,0,0,  4, 0,2'b00, 0,0,0,0);
        add(1,0,2'b00,0,0,0,  5, 0,2'b00, 0,0,0,0);
        add(1,0,2'b00,0,0,0,  6, 0,2'b00, 0,0,0,0);
        add(1,0,2'b00,0,0,0,  7, 0,2'b00, 0,0,0,0);
        add(0,1,2'b00,0,0,0,  7, 0,2'b00, 0,0,1,0);
        add(0,0,2'b00,0,0,0,  7, 0,2'b00, 0,0,0,0);
        add(1,0,2'b00,0,0,0,  8, 0,2'b00, 0,0,0,0);
        add(1,0,2'b00,0,0,0,  8, 0,2'b00, 0,0,1,0);
        // vend item 1 from 8: coin rejected and cancel ignored in VEND, dollar change
        add(0,0,2'b01,0,0,0,  8, 1,2'b01, 0,0,0,1);
        add(1,0,2'b00,0,0,0,  8, 1,2'b01, 0,0,1,1);
        add(0,0,2'b10,1,0,0,  8, 1,2'b01, 0,0,0,1);
        add(0,0,2'b00,0,1,0,  4, 0,2'b00, 1,1,0,1);
        add(0,0,2'b00,0,0,1,  0, 0,2'b00, 0,0,0,1);
        add(0,0,2'b00,0,0,0,  0, 0,2'b00, 0,0,0,0);
        // credit 5, cancel: dollar, GAP, quarter; coins rejected during payout
        add(0,1,2'b00,0,0,0,  4, 0,2'b00, 0,0,0,0);
        add(1,0,2'b00,0,0,0,  5, 0,2'b00, 0,0,0,0);
        add(0,0,2'b00,1,0,0,  5, 0,2'b00, 1,1,0,1);
        add(1,0,2'b00,0,0,0,  5, 0,2'b00, 1,1,1,1);
        add(0,0,2'b00,0,0,1,  1, 0,2'b00, 0,0,0,1);
        add(1,0,2'b00,0,0,0,  1, 0,2'b00, 1,0,1,1);
        add(0,0,2'b00,0,0,1,  0, 0,2'b00, 0,0,0,1);
        add(0,0,2'b00,0,0,0,  0, 0,2'b00, 0,0,0,0);
        // both coins together; insufficient / invalid selections; coin beats selection
        add(1,1,2'b00,0,0,0,  4, 0,2'b00, 0,0,1,0);
        add(0,0,2'b10,0,0,0,  4, 0,2'b00, 0,0,0,0);
        add(0,0,2'b11,0,0,0,  4, 0,2'b00, 0,0,0,0);
        add(1,0,2'b01,0,0,0,  5, 0,2'b00, 0,0,0,0);
        // cancel beats a simultaneous coin, which is rejected
        add(0,1,2'b00,1,0,0,  5, 0,2'b00, 1,1,1,1);
        add(0,0,2'b00,0,0,0,  5, 0,2'b00, 1,1,0,1);

        drive(0,0,2'b00,0,0,0);
        reset = 1'b1;
        step();
        step();
        chk_idle_zero("reset");
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].q, vecs[i].d, vecs[i].sel, vecs[i].c, vecs[i].vd, vecs[i].ack);
            step();
            chk($sformatf("v%0d credit", i), 8'(credit), 8'(vecs[i].credit));
            chk($sformatf("v%0d vend_req", i), 8'(vend_req), 8'(vecs[i].vreq));
            chk($sformatf("v%0d vend_item", i), 8'(vend_item), 8'(vecs[i].vitem));
            chk($sformatf("v%0d coin_req", i), 8'(coin_req), 8'(vecs[i].creq));
            chk($sformatf("v%0d coin_dollar", i), 8'(coin_dollar), 8'(vecs[i].cdol));
            chk($sformatf("v%0d coin_reject", i), 8'(coin_reject), 8'(vecs[i].crej));
            chk($sformatf("v%0d busy", i), 8'(busy), 8'(vecs[i].busy));
            chk($sformatf("v%0d vend_fault", i), 8'(vend_fault), 8'd0);
        end

        // Reset mid-PAY while coin_req is held: everything returns to zero.
        drive(0,0,2'b00,0,0,0);
        reset = 1'b1;
        step();
        chk_idle_zero("midpay_reset");
        reset = 1'b0;
        // A stale hopper ack after reset must not touch anything.
        drive(0,0,2'b00,0,0,1);
        step();
        chk_idle_zero("post_reset_ack");
        drive(1,0,2'b00,0,0,0);
        step();
        chk("post_reset quarter credit", 8'(credit), 8'd1);
        chk("post_reset quarter busy", 8'(busy), 8'd0);

`ifdef VEND_TIMEOUT_EN
        begin
            int n;
            drive(0,0,2'b00,0,0,0);
            reset = 1'b1;
            step();
            reset = 1'b0;
            drive(0,1,2'b00,0,0,0);
            step();
            drive(0,0,2'b01,0,0,0);
            step();
            chk("to vend_req", 8'(vend_req), 8'd1);
            drive(0,0,2'b00,0,0,0);
            // First VEND cycle already sampled; fault expected TO cycles after entry.
            n = 1;
            while (!vend_fault && n < 50) begin
                step();
                n++;
            end
            chk("to fault seen", 8'(vend_fault), 8'd1);
            chk("to fault cycle", 8'(n), 8'(TO + 1));
            chk("to vend_req dropped", 8'(vend_req), 8'd0);
            chk("to refund dollar", 8'(coin_dollar), 8'd1);
            chk("to refund req", 8'(coin_req), 8'd1);
            chk("to credit kept", 8'(credit), 8'd4);
            drive(0,0,2'b00,0,0,1);
            step();
            chk("to fault pulse", 8'(vend_fault), 8'd0);
            chk("to credit after ack", 8'(credit), 8'd0);
            drive(0,0,2'b00,0,0,0);
            step();
            chk("to back idle", 8'(busy), 8'd0);
        end
`endif

        drive(0,0,2'b00,0,0,0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
